// File: rtl/ma_mem_unit_pkg.sv
// Shared pipeline types and stage indices, plus memory-stage FSM states,
// RV32 funct3 access codes and access-size helpers.
`ifndef MA_MEM_UNIT_PKG_SV
`define MA_MEM_UNIT_PKG_SV

`define PC    0
`define IF_ID 1
`define ID_EX 2
`define EX_MA 3

package ma_mem_unit_pkg;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef struct packed {
    logic       stall_req;
    logic [3:0] flush_req;
  } PipeRequest;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} MemState;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} AccSize;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved funct3 codes fall through to word accesses.
  function automatic AccSize acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
    case (acc_size(f3))
      SZ_H:    return offset[0];
      SZ_W:    return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`endif

// File: rtl/ma_mem_unit_align.sv
// Byte-lane shaping: store strobe/data replication and load lane select with
// sign or zero extension. Purely combinational.
module mem_align
  import ma_mem_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_offset,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_strb,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;
  assign shifted = ld_word >> {ld_offset, 3'b000};

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = st_data;
    case (acc_size(st_funct3))
      SZ_B: begin
        st_strb  = 4'b0001 << st_offset;
        st_wdata = {(XLEN/8){st_data[7:0]}};
      end
      SZ_H: begin
        st_strb  = 4'b0011 << st_offset;
        st_wdata = {(XLEN/16){st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ma_mem_unit.sv
// Memory-access stage requester: runs one load/store over a valid/ready bus,
// stalls the pipe while it is outstanding and flushes on misaligned accesses.
module ma_mem_unit
  import ma_mem_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  PipeControl      ex_ma_ctrl,
  input  logic            op_valid,
  input  logic            op_load,
  input  logic            op_store,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_we,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_resp_valid,
  input  logic [XLEN-1:0] bus_rdata,
  output PipeRequest      ma_req,
  output logic            ld_valid,
  output logic [XLEN-1:0] ld_data,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  MemState         state_q, state_d;
  logic            abort_q, abort_d;
  logic [XLEN-1:0] addr_q, wdata_q, ld_data_q;
  logic [3:0]      wstrb_q;
  logic [2:0]      funct3_q;
  logic            we_q, load_q;

  logic            mem_op, mis, accept;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_wdata, ld_ext;
  logic            unused_stall;

  // EX/MA stall is handled by the pipe itself; only flush matters here.
  assign unused_stall = ex_ma_ctrl.stall;

  assign mem_op = op_valid && (op_load || op_store);
  assign mis    = mem_op && misaligned(op_funct3, op_addr[1:0]);
  assign accept = (state_q == IDLE) && mem_op && !mis;

  mem_align #(.XLEN(XLEN)) u_align (
    .st_funct3 (op_funct3),
    .st_offset (op_addr[1:0]),
    .st_data   (op_wdata),
    .st_strb   (st_strb),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_offset (addr_q[1:0]),
    .ld_word   (bus_rdata),
    .ld_data   (ld_ext)
  );

  always_comb begin
    state_d       = state_q;
    abort_d       = abort_q;
    bus_req_valid = 1'b0;
    bus_addr      = '0;
    bus_we        = 1'b0;
    bus_wstrb     = '0;
    bus_wdata     = '0;
    ma_req        = '0;
    ld_valid      = 1'b0;
    fault         = 1'b0;
    fault_addr    = '0;

    // Outside IDLE the bus fields replay the values captured at accept.
    if (state_q != IDLE) begin
      bus_addr  = {addr_q[XLEN-1:2], 2'b00};
      bus_we    = we_q;
      bus_wstrb = wstrb_q;
      bus_wdata = wdata_q;
    end

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (mis) begin
          fault                    = 1'b1;
          fault_addr               = op_addr;
          ma_req.flush_req[`PC]    = 1'b1;
          ma_req.flush_req[`IF_ID] = 1'b1;
          ma_req.flush_req[`ID_EX] = 1'b1;
          ma_req.flush_req[`EX_MA] = 1'b1;
        end else if (mem_op) begin
          bus_req_valid    = 1'b1;
          ma_req.stall_req = 1'b1;
          bus_addr         = {op_addr[XLEN-1:2], 2'b00};
          bus_we           = op_store;
          bus_wstrb        = op_store ? st_strb : 4'b0000;
          bus_wdata        = op_store ? st_wdata : '0;
          state_d          = bus_req_ready ? WAIT : REQ;
        end
      end
      REQ: begin
        bus_req_valid    = 1'b1;
        ma_req.stall_req = 1'b1;
        if (ex_ma_ctrl.flush) abort_d = 1'b1;
        if (bus_req_ready) state_d = WAIT;
      end
      WAIT: begin
        ma_req.stall_req = 1'b1;
        if (ex_ma_ctrl.flush) abort_d = 1'b1;
        if (bus_resp_valid) state_d = DONE;
      end
      DONE: begin
        ld_valid = load_q && !abort_q;
        abort_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign ld_data = ld_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      abort_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (accept) begin
        addr_q   <= op_addr;
        wdata_q  <= bus_wdata;
        wstrb_q  <= bus_wstrb;
        funct3_q <= op_funct3;
        we_q     <= op_store;
        load_q   <= op_load;
      end
      if (state_q == WAIT && bus_resp_valid && load_q) ld_data_q <= ld_ext;
    end
  end

endmodule

// File: tb/tb_ma_mem_unit.sv
// Directed and randomized checks of ma_mem_unit against a byte-level model of
// RV32 load/store shaping and the expected per-cycle handshake sequence.
module tb_ma_mem_unit;
  import ma_mem_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  PipeControl  ex_ma_ctrl;
  logic        op_valid, op_load, op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        bus_req_valid, bus_req_ready, bus_we, bus_resp_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  PipeRequest  ma_req;
  logic        ld_valid, fault;
  logic [31:0] ld_data, fault_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ma_mem_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_ma_ctrl     (ex_ma_ctrl),
    .op_valid       (op_valid),
    .op_load        (op_load),
    .op_store       (op_store),
    .op_funct3      (op_funct3),
    .op_addr        (op_addr),
    .op_wdata       (op_wdata),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_addr       (bus_addr),
    .bus_we         (bus_we),
    .bus_wstrb      (bus_wstrb),
    .bus_wdata      (bus_wdata),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata),
    .ma_req         (ma_req),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .fault          (fault),
    .fault_addr     (fault_addr)
  );

  logic [140:0] all_out;
  logic [7:0]   ctl;
  assign all_out = {bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata, ma_req, ld_valid,
                    ld_data, fault, fault_addr};
  // {req_valid, stall_req, ld_valid, fault, flush_req[3:0]}
  assign ctl = {bus_req_valid, ma_req.stall_req, ld_valid, fault, ma_req.flush_req};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: byte-oriented view of an RV32 access ----
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s = '0;
    for (int k = 0; k < size_of(f3); k++) s[int'(a[1:0]) + k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = wd[8*(lane % size_of(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v = '0;
    int sz = size_of(f3);
    for (int k = 0; k < sz; k++) v[8*k +: 8] = rd[8*(int'(a[1:0]) + k) +: 8];
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  task automatic drive_op(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    op_valid = v; op_load = ld; op_store = st; op_funct3 = f3; op_addr = a; op_wdata = wd;
  endtask

  task automatic idle_inputs();
    drive_op(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = $urandom;
    ex_ma_ctrl = '0;
  endtask

  // Ready rises after rdly REQ cycles, response arrives dly cycles after accept.
  task automatic run_op(input string tag, input bit ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int rdly, input int dly, input int flush_at, input bit junk);
    int  n = rdly + dly + 2;
    bit  aborted;
    bit  in_req;
    bit  exp_ldv;
    aborted = (flush_at >= 1) && (flush_at <= rdly + dly);
    for (int c = 0; c < n; c++) begin
      drive_op(1'b1, ld, !ld, f3, a, wd);
      in_req         = (c <= rdly);
      bus_req_ready  = (c == rdly);
      bus_resp_valid = (c == rdly + dly) || (junk && in_req);
      bus_rdata      = (c == rdly + dly) ? rd : $urandom;
      ex_ma_ctrl     = '{stall: 1'b0, flush: (c == flush_at)};
      @(negedge clk);
      exp_ldv = (c == n - 1) && ld && !aborted;
      chk($sformatf("%s_ctl_c%0d", tag, c), ctl,
          {in_req, (c < n - 1), exp_ldv, 1'b0, 4'b0000});
      if (in_req) begin
        chk($sformatf("%s_addr_c%0d", tag, c), bus_addr, {a[31:2], 2'b00});
        chk($sformatf("%s_we_c%0d", tag, c), bus_we, !ld);
        if (!ld) begin
          chk($sformatf("%s_wstrb_c%0d", tag, c), bus_wstrb, m_strb(f3, a));
          chk($sformatf("%s_wdata_c%0d", tag, c), bus_wdata, m_wdata(f3, wd));
        end
      end
      if (exp_ldv) chk($sformatf("%s_ld_data", tag), ld_data, m_load(f3, a, rd));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_mis(input string tag, input bit ld, input logic [2:0] f3,
                         input logic [31:0] a);
    drive_op(1'b1, ld, !ld, f3, a, $urandom);
    bus_req_ready = 1'b1; bus_resp_valid = 1'b0; ex_ma_ctrl = '0;
    @(negedge clk);
    chk({tag, "_ctl"}, ctl, {1'b0, 1'b0, 1'b0, 1'b1, 4'b1111});
    chk({tag, "_fault_addr"}, fault_addr, a);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({tag, "_after_idle"}, ctl, 8'h00);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit          ld;
    int          rdly, dly, fl;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", all_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory instruction in IDLE keeps everything quiet.
    drive_op(1'b1, 1'b0, 1'b0, 3'd2, 32'h1234_5678, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("non_mem_op_quiet", all_out, '0);
    @(posedge clk); #1;

    run_op("t1_lb", 1'b1, F3_B, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 1, -1, 1'b0);
    idle_inputs();
    @(negedge clk);
    chk("t1_ld_data_held", ld_data, 32'hFFFF_FF80);
    @(posedge clk); #1;

    run_op("t2_sh", 1'b0, F3_H, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 1, -1, 1'b0);
    run_op("t3_lw_ready_low", 1'b1, F3_W, 32'h0000_4008, 32'h0, 32'hDEAD_BEEF, 4, 1, -1, 1'b1);
    run_mis("t4_mis_lw", 1'b1, F3_W, 32'h0000_3001);
    run_op("t5_flush_wait", 1'b1, F3_HU, 32'h0000_5006, 32'h0, 32'h8765_4321, 0, 2, 1, 1'b0);
    run_op("t5_next_op", 1'b1, F3_LH_or_bu(), 32'h0000_5005, 32'h0, 32'h00F0_0000, 1, 1, -1, 1'b0);

    // Reset while a request is waiting for ready.
    drive_op(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_6000, 32'h0);
    bus_req_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_in_req", ctl, {1'b1, 1'b1, 1'b0, 1'b0, 4'b0000});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("t6_after_reset", all_out, '0);
    @(posedge clk); #1;
    run_op("t6_lw_after", 1'b1, F3_W, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 0, 1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 32'd1);
      if (is_mis(f3, a)) begin
        run_mis($sformatf("rnd%0d_mis", i), ld, f3, a);
      end else begin
        rdly = $urandom_range(0, 3);
        dly  = $urandom_range(1, 3);
        fl   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rdly + dly) : -1;
        run_op($sformatf("rnd%0d", i), ld, f3, a, $urandom, $urandom, rdly, dly, fl,
               1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) begin
        idle_inputs();
        @(negedge clk);
        chk($sformatf("rnd%0d_gap", i), ctl, 8'h00);
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic [2:0] F3_LH_or_bu();
    return F3_BU;
  endfunction

endmodule

// File: doc/ma_mem_unit.md
# ma_mem_unit

Memory-access-stage requester. Executes the load/store held in the EX/MA register over a valid/ready data bus and is the producer of the MA stage's `PipeRequest`. It raises `stall_req` while an access is outstanding and raises `flush_req` on a misaligned address. The pipeline control unit turns these requests into per-register `PipeControl`.

## Interface

**Parameters**
- `XLEN`, default 32: data and address width.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ex_ma_ctrl` in `PipeControl`: stall and flush for the EX/MA register.
- `op_valid` in 1: the EX/MA register holds a valid instruction.
- `op_load` in 1: the instruction is a load.
- `op_store` in 1: the instruction is a store. Never asserted together with `op_load`.
- `op_funct3` in 3: RV32 access size and sign encoding.
- `op_addr` in `XLEN`: effective address.
- `op_wdata` in `XLEN`: store data, unshifted.
- `bus_req_valid` out 1: bus request valid.
- `bus_req_ready` in 1: bus accepts the request.
- `bus_addr` out `XLEN`: word-aligned address (`op_addr & ~3`).
- `bus_we` out 1: write enable.
- `bus_wstrb` out 4: byte strobes.
- `bus_wdata` out `XLEN`: lane-replicated store data.
- `bus_resp_valid` in 1: response or write acknowledge.
- `bus_rdata` in `XLEN`: raw read word.
- `ma_req` out `PipeRequest`: `stall_req` plus `flush_req` indexed by `` `PC ``, `` `IF_ID ``, `` `ID_EX ``, `` `EX_MA ``.
- `ld_valid` out 1: one-cycle pulse; `ld_data` is valid.
- `ld_data` out `XLEN`: extended load result.
- `fault` out 1: one-cycle misaligned-access pulse.
- `fault_addr` out `XLEN`: the faulting address.

## Operation

**Memory op.** A memory op is present when `op_valid && (op_load || op_store)`.

**Misalignment** (checked in IDLE only):
- Halfword with `addr[0]=1` is misaligned.
- Word with `addr[1:0]!=0` is misaligned.
- On a misaligned op, in that same cycle:
  - issue no bus request;
  - `stall_req=0`;
  - assert `flush_req` bits `` `PC ``, `` `IF_ID ``, `` `ID_EX ``, `` `EX_MA `` and `fault=1`;
  - `fault_addr=op_addr`;
  - stay in IDLE.

**FSM states:**
- **IDLE**
  - No memory op: all outputs 0.
  - Aligned op present: `bus_req_valid=1`, `stall_req=1`.
  - `bus_req_ready=1` → WAIT; otherwise → REQ.
- **REQ**
  - `bus_req_valid=1` with `bus_addr`, `bus_we`, `bus_wstrb`, `bus_wdata` held stable. Drive them from registers captured on leaving IDLE.
  - `stall_req=1`.
  - `bus_req_ready` → WAIT.
- **WAIT**
  - `stall_req=1`.
  - `bus_resp_valid` → DONE. For loads, capture the extended `bus_rdata` at that edge.
- **DONE**
  - `stall_req=0`.
  - For loads, `ld_valid=1` unless aborted.
  - → IDLE unconditionally. This cycle the EX/MA register advances, so the op is not reissued.

**Store shaping:**
- SB: `wstrb = 4'b0001 << addr[1:0]`; `wdata = {4{b}}`.
- SH: `wstrb = 4'b0011 << addr[1:0]`; `wdata = {2{h}}`.
- SW: `wstrb = 4'b1111`.

**Load extraction:**
- Byte and halfword are selected by `addr[1:0]` from the registered address.
- LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.
- Reserved funct3 codes are treated as LW or SW.

**Boundary cases:**
- **Flush during REQ or WAIT:** `ex_ma_ctrl.flush` set in REQ or WAIT latches an `abort` flag.
  - `bus_req_valid` never drops before ready.
  - The access completes and `stall_req` stays high until DONE.
  - In DONE, `ld_valid` is suppressed.
  - `abort` clears on entering IDLE.
- **Flush in IDLE:** ignored. The op vanishes next cycle.
- **Early response:** a `bus_resp_valid` in IDLE or REQ is a protocol error and is ignored.
- **Reset mid-access:** returns to IDLE immediately. The outstanding bus transaction is abandoned. The system resets the bus concurrently.

## Timing

- **Reset values:** state IDLE, `abort=0`, and every output 0, including `ma_req` and `ld_data`.
- **Combinational outputs:** `stall_req` and `bus_req_valid` are combinational from state and op inputs in IDLE. All other bus outputs come from registers after IDLE.
- **Minimum load occupancy:** 3 cycles (IDLE accept, WAIT with response, DONE). `ld_valid` is asserted in the 3rd cycle.
- **General occupancy:** 3 + (ready wait cycles) + (response wait cycles beyond 1).
- **Response latency:** at least 1 cycle after acceptance. The response is never accepted in the same cycle as the request.
- **Fault:** 0-cycle latency; `fault` and `flush_req` are asserted in the cycle the op is first present.
- **Back-to-back ops:** two consecutive loads are spaced at minimum 3 cycles apart at accept. There is no idle bubble after DONE.

## Structure

- **Shared package (`common.sv`):**
  - add a `MemState` enum (IDLE, REQ, WAIT, DONE);
  - add funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - reuse the existing `PipeRequest`, `PipeControl` and the stage index macros.
- **Sub-module `mem_align`:** combinational; store strobe and data replication, plus load lane select and extension. Unit-testable alone.
- **Top level:** the FSM, capture registers, abort flag and `PipeRequest` assembly.

## Test plan

1. **Aligned LB.** `op_addr=0x1003`, LB, ready immediate, response next cycle with `rdata=0x80AABBCC`.
   - `bus_addr=0x1000`.
   - `stall_req` high for 2 cycles.
   - `ld_data=0xFFFFFF80` with `ld_valid` in cycle 3.
2. **SH.** `op_addr=0x2002`, `wdata=0x1234ABCD`.
   - `wstrb=4'b1100`, `bus_wdata=0xABCDABCD`, `bus_we=1`.
   - `ld_valid` never asserted.
3. **Ready held low.** LW with `bus_req_ready` low for 4 cycles.
   - `bus_req_valid` and `bus_addr` stable throughout.
   - Total `stall_req` is 6 cycles (REQ 4 + WAIT 1 + IDLE 1); DONE has stall 0.
4. **Misaligned LW.** `op_addr=0x3001`.
   - Same cycle: `fault=1`, `fault_addr=0x3001`, all four `flush_req` bits set, `bus_req_valid=0`, `stall_req=0`.
5. **Flush during WAIT.** `ex_ma_ctrl.flush=1` for one cycle in WAIT.
   - The response is still consumed and `stall_req` drops only in DONE.
   - `ld_valid=0`.
   - The next op is accepted normally.
6. **Reset in REQ.** Assert `rst` while in REQ.
   - Next cycle: IDLE, all outputs 0.
   - A subsequent LW completes normally.
